lfsr_roll_gen: RTL

- Parametrised "dice-roll" pseudo-random generator for the 7-segment display path.
- Free-runs a Galois LFSR, and its update rate slows down through N_STAGES stages until it settles on a final value.
- Adds several features:
  - width, stage-count, period and tap generality;
  - a loadable seed;
  - an abort control (stop);
  - status outputs (update strobe, busy, done pulse, current stage).
- Drives the display decoder directly, and its status outputs go to the top-level controller.

---
 rtl/lfsr_roll_gen_if.sv | 27 ++
 rtl/lfsr_roll_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lfsr_roll_gen_if.sv
// Control/status bundle between the dice-roll generator, its controller and the display decoder.
interface lfsr_roll_gen_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned N_STAGES = 3
);
  localparam int unsigned STAGE_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic               i_start;
  logic               i_stop;
  logic               i_seed_valid;
  logic [WIDTH-1:0]   i_seed;
  logic [WIDTH-1:0]   o_random_out;
  logic               o_update;
  logic               o_busy;
  logic               o_done;
  logic [STAGE_W-1:0] o_stage;

  modport master (
    output i_start, i_stop, i_seed_valid, i_seed,
    input  o_random_out, o_update, o_busy, o_done, o_stage
  );

  modport slave (
    input  i_start, i_stop, i_seed_valid, i_seed,
    output o_random_out, o_update, o_busy, o_done, o_stage
  );
endinterface

// File: rtl/lfsr_roll_gen.sv
// Dice-roll generator: a Galois LFSR whose step rate slows through N_STAGES stages
// before settling on a final value; supports a loadable seed and an abort control.
module lfsr_roll_gen #(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
  parameter int unsigned      N_STAGES     = 3,
  parameter int unsigned      STAGE_LEN    = 2**24,
  parameter int unsigned      BASE_PERIOD  = 2**16,
  parameter int unsigned      PERIOD_SHIFT = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  lfsr_roll_gen_if.slave bus
);

  localparam int unsigned     STAGE_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int unsigned     SCNT_W     = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
  localparam longint unsigned MAX_PERIOD = 64'(BASE_PERIOD) << ((N_STAGES - 1) * PERIOD_SHIFT);
  localparam int unsigned     PCNT_W     = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;

  localparam logic [SCNT_W-1:0]  STAGE_END  = SCNT_W'(STAGE_LEN - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

  if (WIDTH < 2 || WIDTH > 16 || N_STAGES < 1 || N_STAGES > 8 || BASE_PERIOD < 1 ||
      MAX_PERIOD > 64'(STAGE_LEN) || MAX_PERIOD >= 64'h1_0000_0000) begin : g_bad_params
    $error("lfsr_roll_gen: parameters out of range (largest period must be <= STAGE_LEN and < 2**32)");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   seed_q, seed_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               update_q, update_d;
  logic               done_q, done_d;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
    return (s == '0) ? '1 : s;
  endfunction

  function automatic logic [PCNT_W-1:0] period_m1(input logic [STAGE_W-1:0] stg);
    longint unsigned p;
    p = 64'(BASE_PERIOD) << (32'(stg) * PERIOD_SHIFT);
    return PCNT_W'(p - 64'd1);
  endfunction

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    value_d  = value_q;
    stage_d  = stage_q;
    scnt_d   = scnt_q;
    pcnt_d   = pcnt_q;
    update_d = 1'b0;
    done_d   = 1'b0;

    if (bus.i_seed_valid) seed_d = seed_fix(bus.i_seed);

    // Start outranks stop; a seed loaded in the same cycle is the one used.
    if (bus.i_start) begin
      state_d = RUN;
      value_d = seed_d;
      stage_d = '0;
      scnt_d  = '0;
      pcnt_d  = '0;
    end else if (state_q == RUN) begin
      if (bus.i_stop) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q == period_m1(stage_q)) begin
          value_d  = lfsr_step(value_q);
          pcnt_d   = '0;
          update_d = 1'b1;
        end
        // Stage end overrides the counter updates but keeps any coincident step.
        if (scnt_q == STAGE_END) begin
          scnt_d = '0;
          pcnt_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      seed_q   <= '1;
      value_q  <= '0;
      stage_q  <= '0;
      scnt_q   <= '0;
      pcnt_q   <= '0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      value_q  <= value_d;
      stage_q  <= stage_d;
      scnt_q   <= scnt_d;
      pcnt_q   <= pcnt_d;
      update_q <= update_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_random_out = value_q;
  assign bus.o_update     = update_q;
  assign bus.o_busy       = (state_q == RUN);
  assign bus.o_done       = done_q;
  assign bus.o_stage      = stage_q;

endmodule
